pool_flatten_buffer: RTL

Collects one complete pooled frame from the maxpool/ReLU stage: three channels of HALF_WIDTH x HALF_HEIGHT signed values, one triple per `valid_in` beat. It then streams the frame out one value per handshake in channel-major, row-major order. It sits between the pooling stage and the fully-connected layer and decouples the pooling stage's push-only output from the FC stage's ready/valid input.

---
 rtl/pool_flatten_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pool_flatten_buffer.sv
// Frame buffer between the pooling stage and the FC layer: captures three
// channels of pooled samples, then streams them out channel-major over ready/valid.
module pool_flatten_buffer #(
  parameter int CONV_BIT    = 15,
  parameter int HALF_WIDTH  = 12,
  parameter int HALF_HEIGHT = 12,
  parameter int POS_BIT     = 8,
  parameter int IDX_BIT     = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] max_value_1,
  input  logic signed [CONV_BIT-1:0] max_value_2,
  input  logic signed [CONV_BIT-1:0] max_value_3,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [CONV_BIT-1:0] out_data,
  output logic [IDX_BIT-1:0]         out_index,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       overflow
);

  localparam int N = HALF_WIDTH * HALF_HEIGHT;
  localparam logic [POS_BIT-1:0] LAST_POS = POS_BIT'(N - 1);
  localparam logic [IDX_BIT-1:0] LAST_IDX = IDX_BIT'(3 * N - 1);

  typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

  state_t                     state;
  logic [POS_BIT-1:0]         wr_pos;
  logic [POS_BIT-1:0]         rd_pos;
  logic [1:0]                 rd_ch;
  logic [POS_BIT-1:0]         nxt_pos;
  logic [1:0]                 nxt_ch;
  logic signed [CONV_BIT-1:0] nxt_sample;

  logic signed [CONV_BIT-1:0] mem0 [N];
  logic signed [CONV_BIT-1:0] mem1 [N];
  logic signed [CONV_BIT-1:0] mem2 [N];

  // Sample storage carries no reset; only FILL writes it.
  always_ff @(posedge clk) begin
    if (state == FILL && valid_in) begin
      mem0[wr_pos] <= max_value_1;
      mem1[wr_pos] <= max_value_2;
      mem2[wr_pos] <= max_value_3;
    end
  end

  // Address of the sample that follows the one currently presented.
  always_comb begin
    nxt_pos = rd_pos + POS_BIT'(1);
    nxt_ch  = rd_ch;
    if (rd_pos == LAST_POS) begin
      nxt_pos = '0;
      nxt_ch  = rd_ch + 2'd1;
    end
    case (nxt_ch)
      2'd0:    nxt_sample = mem0[nxt_pos];
      2'd1:    nxt_sample = mem1[nxt_pos];
      default: nxt_sample = mem2[nxt_pos];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_pos     <= '0;
      rd_pos     <= '0;
      rd_ch      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (valid_in && state != FILL) overflow <= 1'b1;
      case (state)
        FILL: begin
          if (valid_in) begin
            if (wr_pos == LAST_POS) begin
              wr_pos <= '0;
              busy   <= 1'b1;
              state  <= LOAD;
            end else begin
              wr_pos <= wr_pos + POS_BIT'(1);
            end
          end
        end
        LOAD: begin
          out_data  <= mem0[0];
          out_index <= '0;
          out_valid <= 1'b1;
          rd_pos    <= '0;
          rd_ch     <= '0;
          state     <= DRAIN;
        end
        DRAIN: begin
          // out_valid is always high here, so out_ready alone is the handshake.
          if (out_ready) begin
            if (out_index == LAST_IDX) begin
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              rd_pos     <= '0;
              rd_ch      <= '0;
              state      <= FILL;
            end else begin
              rd_pos    <= nxt_pos;
              rd_ch     <= nxt_ch;
              out_data  <= nxt_sample;
              out_index <= out_index + IDX_BIT'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
